// File: rtl/cnn_pkg.sv
// Shared helpers for the CNN datapath stages: accumulator sizing and signed saturation.
// Pure package, no logic; functions are elaborated as constants or combinational clip logic.
package cnn_pkg;

    localparam int SAT_W = 64;

    typedef logic signed [SAT_W-1:0] wide_t;

    // Width that holds the sum of taps products of two signed data_w operands without overflow.
    function automatic int acc_width(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps);
    endfunction

    function automatic wide_t sat_signed(input wide_t value, input int out_w);
        wide_t hi;
        wide_t lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        return value;
    endfunction

endpackage

// File: rtl/mac_requant.sv
// Requantizer: arithmetic shift, optional ReLU, signed saturation to OUT_W with clip flag.
// Latency: purely combinational.
// Backpressure: none, no state.
module mac_requant
    import cnn_pkg::*;
#(
    parameter int ACC_W   = 20,
    parameter int SHIFT   = 0,
    parameter int RELU_EN = 1,
    parameter int OUT_W   = 8
) (
    input  logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] data,
    output logic             ovf
);

    logic signed [ACC_W-1:0] shifted;
    wide_t                   relu_v;
    wide_t                   sat_v;

    always_comb begin
        shifted = $signed(sum) >>> SHIFT;
        relu_v  = {{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted};
        // ReLU clamp happens before the clip so it never counts as an overflow.
        if ((RELU_EN != 0) && relu_v[SAT_W-1])
            relu_v = '0;
        sat_v = sat_signed(relu_v, OUT_W);
        ovf   = (sat_v != relu_v);
        data  = sat_v[OUT_W-1:0];
    end

endmodule

// File: rtl/conv_mac_accum.sv
// Kernel MAC stage: accumulates TAPS pixel*weight pairs per window, emits one requantized result.
// Latency: result valid 2 cycles after the accept of the last pair; 1 pair/cycle sustained.
// Backpressure: en=0 or a held unaccepted result freezes every register and drops in_ready.
module conv_mac_accum
    import cnn_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TAPS    = 9,
    parameter int SHIFT   = 0,
    parameter int RELU_EN = 1,
    parameter int OUT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pix,
    input  logic [DATA_W-1:0] in_wgt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              busy
);

    localparam int ACC_W  = acc_width(DATA_W, TAPS);
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    logic                     stall;
    logic                     accept;
    logic [CNT_W-1:0]         tap_cnt;
    logic signed [PROD_W-1:0] p1_prod;
    logic                     p1_valid;
    logic                     p1_last;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic [OUT_W-1:0]         rq_data;
    logic                     rq_ovf;

    assign stall    = ~en | (out_valid & ~out_ready);
    assign in_ready = ~stall & ~clr & ~rst;
    assign accept   = in_valid & in_ready;
    assign sum      = acc + {{(ACC_W-PROD_W){p1_prod[PROD_W-1]}}, p1_prod};
    assign busy     = (tap_cnt != '0) | p1_valid;

    mac_requant #(
        .ACC_W   (ACC_W),
        .SHIFT   (SHIFT),
        .RELU_EN (RELU_EN),
        .OUT_W   (OUT_W)
    ) u_requant (
        .sum  (sum),
        .data (rq_data),
        .ovf  (rq_ovf)
    );

    // Stage 1: tap counter and product register. clr aborts even while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt  <= '0;
            p1_valid <= 1'b0;
            p1_last  <= 1'b0;
            p1_prod  <= '0;
        end else if (clr) begin
            tap_cnt  <= '0;
            p1_valid <= 1'b0;
        end else if (!stall) begin
            p1_valid <= accept;
            if (accept) begin
                p1_prod <= $signed(in_pix) * $signed(in_wgt);
                p1_last <= (tap_cnt == LAST_TAP);
                tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 2: accumulator, restarted after each window's last product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (!stall && p1_valid)
            acc <= p1_last ? '0 : sum;
    end

    // Output register survives clr; a new result may replace one being taken this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            if (p1_valid && p1_last && !clr) begin
                out_valid <= 1'b1;
                out_data  <= rq_data;
                out_ovf   <= rq_ovf;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_accum.sv
// Directed bench for conv_mac_accum: default instance plus RELU_EN=0 and SHIFT=10 instances on shared stimulus.
module tb_conv_mac_accum;

    logic       clk, rst, en, clr, in_valid, out_ready;
    logic [7:0] in_pix, in_wgt;

    logic       in_ready, out_valid, out_ovf, busy;
    logic [7:0] out_data;
    logic       in_ready_nr, out_valid_nr, out_ovf_nr, busy_nr;
    logic [7:0] out_data_nr;
    logic       in_ready_sh, out_valid_sh, out_ovf_sh, busy_sh;
    logic [7:0] out_data_sh;

    int compared   = 0;
    int mismatched = 0;

    logic [8:0] q_def[$];
    logic [8:0] q_nr[$];
    logic [8:0] q_sh[$];

    conv_mac_accum dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_wgt(in_wgt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .busy(busy)
    );

    conv_mac_accum #(.RELU_EN(0)) dut_nr (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_nr), .in_pix(in_pix), .in_wgt(in_wgt),
        .out_valid(out_valid_nr), .out_ready(out_ready), .out_data(out_data_nr),
        .out_ovf(out_ovf_nr), .busy(busy_nr)
    );

    conv_mac_accum #(.SHIFT(10)) dut_sh (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_sh), .in_pix(in_pix), .in_wgt(in_wgt),
        .out_valid(out_valid_sh), .out_ready(out_ready), .out_data(out_data_sh),
        .out_ovf(out_ovf_sh), .busy(busy_sh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completed output handshakes, captured with pre-edge values.
    always @(posedge clk) begin
        if (out_valid && out_ready && en) begin
            q_def.push_back({out_ovf, out_data});
            q_nr.push_back({out_ovf_nr, out_data_nr});
            q_sh.push_back({out_ovf_sh, out_data_sh});
        end
    end

    function automatic logic [8:0] ex(input logic o, input int v);
        logic [31:0] t;
        t = v;
        return {o, t[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pair(input int p, input int w);
        int t;
        logic [31:0] pv, wv;
        t = 0;
        pv = p;
        wv = w;
        in_valid = 1'b1;
        in_pix   = pv[7:0];
        in_wgt   = wv[7:0];
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [8:0] e_def,
                                 input logic [8:0] e_nr, input logic [8:0] e_sh);
        int t;
        t = 0;
        while (q_def.size() == 0 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (q_def.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_def"}, 32'(q_def.pop_front()), 32'(e_def));
            check({tag, "_nr"},  32'(q_nr.pop_front()),  32'(e_nr));
            check({tag, "_sh"},  32'(q_sh.pop_front()),  32'(e_sh));
        end
    endtask

    initial begin
        logic [7:0] held;
        int t;
        rst = 1'b1; en = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pix = '0; in_wgt = '0;
        #2;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // 1: pix=1, wgt=1..9 -> 45, latency 2 cycles after the 9th accept
        for (int i = 1; i <= 9; i++) send_pair(1, i);
        check("t1_lat_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_lat_rise", 32'(out_valid), 32'd1);
        expect_result("t1", ex(0, 45), ex(0, 45), ex(0, 0));

        // 2: -1*10 x9 = -90; ReLU -> 0, passthrough fits in 8 bits, SHIFT=10 -> -1 -> 0
        for (int i = 0; i < 9; i++) send_pair(-1, 10);
        expect_result("t2a", ex(0, 0), ex(0, -90), ex(0, 0));
        // -127*127 x9 = -145161: passthrough clips to -128; >>>10 gives -142 -> ReLU 0
        for (int i = 0; i < 9; i++) send_pair(-127, 127);
        expect_result("t2b", ex(0, 0), ex(1, -128), ex(0, 0));

        // 3: 127*127 x9 = 145161 -> clip 127; >>>10 = 141 -> clip 127
        for (int i = 0; i < 9; i++) send_pair(127, 127);
        expect_result("t3", ex(1, 127), ex(1, 127), ex(1, 127));

        // 4: back-to-back windows with 5 cycles of output backpressure on the first result
        fork
            begin
                for (int w = 0; w < 2; w++)
                    for (int i = 1; i <= 9; i++) send_pair(1, i);
            end
            begin
                t = 0;
                while (!out_valid && t < 60) begin
                    @(posedge clk); #1;
                    t++;
                end
                if (!out_valid) check("t4_wait_timeout", 32'd0, 32'd1);
                out_ready = 1'b0;
                held = out_data;
                repeat (5) begin
                    @(negedge clk);
                    check("t4_hold_valid", 32'(out_valid), 32'd1);
                    check("t4_hold_data",  32'(out_data),  32'(held));
                    check("t4_in_ready",   32'(in_ready),  32'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        expect_result("t4_r1", ex(0, 45), ex(0, 45), ex(0, 0));
        expect_result("t4_r2", ex(0, 45), ex(0, 45), ex(0, 0));
        repeat (5) begin @(posedge clk); #1; end
        check("t4_no_extra", 32'(q_def.size()), 32'd0);
        check("t4_busy",     32'(busy),         32'd0);

        // 5: 4 pairs, clr pulse, then 9 x (1,2) -> 18
        for (int i = 0; i < 4; i++) send_pair(5, 5);
        clr = 1'b1;
        #1;
        check("t5_clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        check("t5_busy_cleared", 32'(busy), 32'd0);
        for (int i = 0; i < 9; i++) send_pair(1, 2);
        expect_result("t5", ex(0, 18), ex(0, 18), ex(0, 0));
        repeat (3) begin @(posedge clk); #1; end
        check("t5_busy_after", 32'(busy),           32'd0);
        check("t5_single",     32'(q_def.size()),   32'd0);

        // 6a: async reset after 5 pairs takes effect before any clock edge
        for (int i = 0; i < 5; i++) send_pair(1, i + 1);
        check("t6_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy",      32'(busy),      32'd0);
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 9; i++) send_pair(1, i);
        expect_result("t6_after_rst", ex(0, 45), ex(0, 45), ex(0, 0));

        // 6b: en low for 3 cycles mid-window freezes, result matches the gapless run
        for (int i = 1; i <= 4; i++) send_pair(1, i);
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_en_in_ready", 32'(in_ready), 32'd0);
            check("t6_en_busy",     32'(busy),     32'd1);
        end
        @(posedge clk); #1;
        en = 1'b1;
        for (int i = 5; i <= 9; i++) send_pair(1, i);
        expect_result("t6_en_gap", ex(0, 45), ex(0, 45), ex(0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
